// File: rtl/dsp_result_collector_pkg.sv
// Shared constants for the DSP result collector slice.
package dsp_result_collector_pkg;

    // P output width of the DSP48A1 (fixed by the primitive)
    localparam int DSP_P_W         = 48;
    // Default user tag width carried alongside each operation
    localparam int TAG_W_DEFAULT   = 4;
    // Default issue-to-P latency (D/B1/M/P registers enabled)
    localparam int DSP_LAT_DEFAULT = 4;
    // Default result FIFO depth
    localparam int DEPTH_DEFAULT   = 8;

endpackage

// File: rtl/dsp_result_collector_fifo.sv
// dsp_rc_fifo: synchronous first-word-fall-through FIFO with flush and occupancy count.
// The head is a combinational read of mem[rd_ptr], zeroed while empty.
module dsp_rc_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 53
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;
    logic          full;

    assign empty  = (count == '0);
    assign full   = (count == FULL_CNT);
    assign do_pop = pop & ~empty;
    assign dout   = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset since the head is masked while empty
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and up/down occupancy counter; flush overrides any same-cycle push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Credit flow control upstream must make a push into a full FIFO impossible
    assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/dsp_result_collector.sv
// dsp_result_collector: tracks ops issued into the DSP, captures P/CARRYOUT when each
// result emerges, and buffers {P, CARRYOUT, tag} for a ready/valid consumer.
// Issue is credit-controlled so the FIFO can never overflow.
module dsp_result_collector
    import dsp_result_collector_pkg::*;
#(
    parameter int LATENCY = DSP_LAT_DEFAULT,
    parameter int DEPTH   = DEPTH_DEFAULT,
    parameter int P_W     = DSP_P_W,
    parameter int TAG_W   = TAG_W_DEFAULT
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     issue_valid,
    input  logic [TAG_W-1:0]         issue_tag,
    output logic                     issue_ready,
    input  logic                     flush,
    input  logic [P_W-1:0]           P,
    input  logic                     CARRYOUT,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [P_W-1:0]           out_p,
    output logic                     out_carry,
    output logic [TAG_W-1:0]         out_tag,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam int FW = P_W + 1 + TAG_W;

    logic [LATENCY-1:0] trk_valid;
    logic [TAG_W-1:0]   trk_tag [LATENCY];
    logic [31:0]        in_flight;
    logic [31:0]        occupancy;
    logic               fifo_empty;
    logic [FW-1:0]      fifo_dout;

    // Credits: every tracked op and every buffered result holds one FIFO slot.
    // fifo_count is taken before any same-cycle pop, which is conservative.
    always_comb begin
        in_flight = '0;
        for (int unsigned i = 0; i < LATENCY; i++) begin
            in_flight = in_flight + {31'b0, trk_valid[i]};
        end
    end

    assign occupancy   = in_flight + 32'(fifo_count);
    assign issue_ready = ~flush & (occupancy < 32'(DEPTH));

    // Tracker shift register mirroring the DSP pipeline: {valid, tag} per stage
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            trk_valid <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                trk_tag[i] <= '0;
            end
        end else if (flush) begin
            trk_valid <= '0;
        end else begin
            trk_valid[0] <= issue_valid & issue_ready;
            trk_tag[0]   <= issue_tag;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                trk_valid[i] <= trk_valid[i-1];
                trk_tag[i]   <= trk_tag[i-1];
            end
        end
    end

    // Sticky overflow on an issue attempt without credit; flush takes priority
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            overflow <= 1'b0;
        end else if (flush) begin
            overflow <= 1'b0;
        end else if (issue_valid && !issue_ready) begin
            overflow <= 1'b1;
        end
    end

    dsp_rc_fifo #(
        .DEPTH (DEPTH),
        .W     (FW)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .flush (flush),
        .push  (trk_valid[LATENCY-1]),
        .din   ({P, CARRYOUT, trk_tag[LATENCY-1]}),
        .pop   (out_valid & out_ready),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    assign out_valid = ~fifo_empty;
    assign {out_p, out_carry, out_tag} = fifo_dout;

endmodule
